// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with any-depth storage, occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a selectable registered or first-word-fall-through read mode.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   cs              chip select; gates wr_en, rd_en and clr_err
//   wr_en, data_in  write request and write data
//   rd_en           read request (pop in FWFT mode)
//   clr_err         clears the sticky error flags
//   data_out        read data
//   empty, full, almost_empty, almost_full, count   occupancy status
//   overflow, underflow                              sticky error flags
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  empty_i;
  logic                  full_i;
  logic                  rd_acc;
  logic                  wr_acc;

  // Status is decoded from the count register only, never from the inputs.
  always_comb begin
    empty_i = (count_q == '0);
    full_i  = (count_q == CW'(FIFO_DEPTH));
  end

  always_comb begin
    rd_acc = cs & rd_en & ~empty_i;
    // A write into a full FIFO is allowed when a read frees a slot on the
    // same edge; wr_ptr == rd_ptr then, and the read samples the old word.
    wr_acc = cs & wr_en & (~full_i | rd_acc);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        dout_q <= mem[rd_ptr];
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A new error event outranks a clear in the same cycle.
      if (cs && wr_en && !wr_acc) begin
        ovf_q <= 1'b1;
      end else if (cs && clr_err) begin
        ovf_q <= 1'b0;
      end

      if (cs && rd_en && !rd_acc) begin
        udf_q <= 1'b1;
      end else if (cs && clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  // dout_q doubles as the last-popped word, which FWFT mode shows when empty.
  always_comb begin
    data_out = (FWFT && !empty_i) ? mem[rd_ptr] : dout_q;
  end

  always_comb begin
    empty        = empty_i;
    full         = full_i;
    almost_empty = (count_q <= CW'(AE_LEVEL));
    almost_full  = (count_q >= CW'(AF_LEVEL));
    count        = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed bench for fifo_sync_flags, one registered-read
// instance and one first-word-fall-through instance (depth 6, AF 5, AE 1).
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Registered-read instance
  logic       a_rst = 1'b0, a_cs = 1'b0, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [2:0] a_count;

  // FWFT instance
  logic       b_rst = 1'b0, b_cs = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [2:0] b_count;

  fifo_sync_flags #(
    .DATA_WIDTH(8), .FIFO_DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(1'b0)
  ) u_a (
    .clk(clk), .rst(a_rst), .cs(a_cs), .wr_en(a_wr), .rd_en(a_rd),
    .data_in(a_din), .clr_err(a_clr), .data_out(a_dout), .empty(a_empty),
    .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_sync_flags #(
    .DATA_WIDTH(8), .FIFO_DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(1'b1)
  ) u_b (
    .clk(clk), .rst(b_rst), .cs(b_cs), .wr_en(b_wr), .rd_en(b_rd),
    .data_in(b_din), .clr_err(b_clr), .data_out(b_dout), .empty(b_empty),
    .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_wr = 1'b1; a_din = d; tick(); a_wr = 1'b0;
  endtask

  task automatic a_pop(input logic [7:0] exp, input string tag);
    a_rd = 1'b1; tick(); a_rd = 1'b0;
    check(tag, 32'(a_dout), 32'(exp));
  endtask

  initial begin
    #1;
    // ---------------- registered-read instance ----------------
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    check("a_rst_count", 32'(a_count), 0);
    check("a_rst_empty", 32'(a_empty), 1);
    check("a_rst_full",  32'(a_full), 0);
    check("a_rst_ae",    32'(a_ae), 1);
    check("a_rst_af",    32'(a_af), 0);
    check("a_rst_dout",  32'(a_dout), 0);
    check("a_rst_ovf",   32'(a_ovf), 0);
    check("a_rst_udf",   32'(a_udf), 0);

    a_cs = 1'b1;
    a_push(8'hA5);
    check("a5_count1", 32'(a_count), 1);
    a_pop(8'hA5, "a5_dout");
    check("a5_count0", 32'(a_count), 0);
    check("a5_empty",  32'(a_empty), 1);
    check("a5_ovf",    32'(a_ovf), 0);
    check("a5_udf",    32'(a_udf), 0);

    for (int i = 1; i <= 6; i++) begin
      a_push(8'(i));
      check("fill_count", 32'(a_count), 32'(i));
      check("fill_ae",    32'(a_ae),   (i <= 1) ? 1 : 0);
      check("fill_af",    32'(a_af),   (i >= 5) ? 1 : 0);
      check("fill_full",  32'(a_full), (i == 6) ? 1 : 0);
    end
    a_push(8'h55);
    check("ovf_flag",  32'(a_ovf), 1);
    check("ovf_count", 32'(a_count), 6);

    for (int i = 1; i <= 6; i++) a_pop(8'(i), "drain_data");
    check("drain_empty", 32'(a_empty), 1);
    check("drain_udf",   32'(a_udf), 0);

    a_pop(8'h06, "udf_hold_dout");
    check("udf_flag", 32'(a_udf), 1);
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    check("clr_ovf", 32'(a_ovf), 0);
    check("clr_udf", 32'(a_udf), 0);
    a_clr = 1'b1; a_rd = 1'b1; tick(); a_clr = 1'b0; a_rd = 1'b0;
    check("clr_vs_udf", 32'(a_udf), 1);
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    check("clr_udf2", 32'(a_udf), 0);

    // pointer wrap
    for (int i = 1; i <= 4; i++) a_push(8'(8'hA0 + i));
    for (int i = 1; i <= 4; i++) a_pop(8'(8'hA0 + i), "pre_wrap_data");
    for (int i = 0; i < 6; i++) a_push(8'(8'h11 + i));
    check("wrap_full", 32'(a_full), 1);
    for (int i = 0; i < 6; i++) a_pop(8'(8'h11 + i), "wrap_data");
    check("wrap_count", 32'(a_count), 0);

    // simultaneous write+read at full
    for (int i = 0; i < 6; i++) a_push(8'(8'h11 + i));
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h77; tick(); a_wr = 1'b0; a_rd = 1'b0;
    check("wt_dout",  32'(a_dout), 32'h11);
    check("wt_count", 32'(a_count), 6);
    check("wt_ovf",   32'(a_ovf), 0);
    for (int i = 1; i < 6; i++) a_pop(8'(8'h11 + i), "wt_data");
    a_pop(8'h77, "wt_last");
    check("wt_empty", 32'(a_empty), 1);

    // simultaneous write+read at empty
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h33; tick(); a_wr = 1'b0; a_rd = 1'b0;
    check("se_count", 32'(a_count), 1);
    check("se_udf",   32'(a_udf), 1);
    a_pop(8'h33, "se_data");
    check("se_count0", 32'(a_count), 0);

    // ---------------- FWFT instance ----------------
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    check("b_rst_empty", 32'(b_empty), 1);
    check("b_rst_dout",  32'(b_dout), 0);
    b_cs = 1'b1;
    b_wr = 1'b1; b_din = 8'h3C; tick(); b_wr = 1'b0;
    check("fw_empty", 32'(b_empty), 0);
    check("fw_dout",  32'(b_dout), 32'h3C);
    b_rd = 1'b1; tick(); b_rd = 1'b0;
    check("fw_pop_empty", 32'(b_empty), 1);
    check("fw_pop_hold",  32'(b_dout), 32'h3C);
    b_wr = 1'b1; b_din = 8'h3D; tick(); b_din = 8'h3E; tick(); b_wr = 1'b0;
    check("fw_head1", 32'(b_dout), 32'h3D);
    b_rd = 1'b1; tick(); b_rd = 1'b0;
    check("fw_head2", 32'(b_dout), 32'h3E);
    check("fw_count", 32'(b_count), 1);
    b_rst = 1'b1; b_wr = 1'b1; b_din = 8'h99; tick(); b_rst = 1'b0; b_wr = 1'b0;
    check("fw_rst_count", 32'(b_count), 0);
    check("fw_rst_empty", 32'(b_empty), 1);
    check("fw_rst_dout",  32'(b_dout), 0);
    tick();
    check("fw_rst_nostore", 32'(b_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
